// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes MIPS field bundles and streams them into instruction memory
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           opens a new load session (honoured in IDLE and DONE only)
//   in_valid/ready  field-bundle handshake; in_last marks the final instruction
//   in_kind         0 RTYPE, 1 ADDI, 2 BEQ, 3 BNE, 4 LW, 5 JUMP (6-7 illegal)
//   in_alufn        RTYPE op: 0 add, 1 sub, 2 and, 3 or, 4 slt (5-7 illegal)
//   in_rs/rt/rd     register fields; in_imm immediate; in_target jump target
//   mem_we/addr/wdata  registered imem write port, one cycle after accept
//   busy, done      FSM in LOAD / DONE
//   err             sticky illegal-bundle flag, cleared by start
//   count           words written this session
module instr_encoder_loader #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [2:0]            in_kind,
    input  logic [2:0]            in_alufn,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte address of the last word in imem.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state, nextState;
    logic [ADDR_WIDTH-1:0]   pointer;
    logic [31:0]             word;
    logic                    legal;
    logic [5:0]              funct;
    logic                    accept;
    logic                    startSession;
    logic                    atLast;

    assign accept       = in_valid && in_ready;
    assign startSession = start && (state != LOAD);
    assign atLast       = (pointer == LAST_ADDR);

    // Field encoder: purely combinational, the result is captured on accept.
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        funct = 6'h00;
        case (in_alufn)
            3'd0:    funct = 6'h20;
            3'd1:    funct = 6'h22;
            3'd2:    funct = 6'h24;
            3'd3:    funct = 6'h25;
            3'd4:    funct = 6'h2A;
            default: funct = 6'h00;
        endcase
        case (in_kind)
            3'd0: begin
                word = {6'h00, in_rs, in_rt, in_rd, 5'b00000, funct};
                if (in_alufn > 3'd4) begin
                    legal = 1'b0;
                end
            end
            3'd1:    word = {6'h08, in_rs, in_rt, in_imm};
            3'd2:    word = {6'h04, in_rs, in_rt, in_imm};
            3'd3:    word = {6'h05, in_rs, in_rt, in_imm};
            3'd4:    word = {6'h23, in_rs, in_rt, in_imm};
            3'd5:    word = {6'h02, in_target};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // A legal bundle landing on the final word ends the session,
                // so the pointer never has to wrap.
                if (accept && (in_last || (legal && atLast))) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    nextState = LOAD;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath. The pointer advances on accept (mem_addr has already captured
    // the old value) so back-to-back accepts produce back-to-back writes;
    // count follows the actual write one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            pointer   <= BASE_ADDR;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                count <= count + ONE;
            end
            if (startSession) begin
                pointer <= BASE_ADDR;
                count   <= '0;
                err     <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= pointer;
                    mem_wdata <= word;
                    if (!atLast) begin
                        pointer <= pointer + WORD_STEP;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  alufn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start4 = 1'b0;
    logic        valid8 = 1'b0, valid4 = 1'b0;
    logic        inLast = 1'b0;
    logic [2:0]  inKind = 3'd0, inAlufn = 3'd0;
    logic [4:0]  inRs = 5'd0, inRt = 5'd0, inRd = 5'd0;
    logic [15:0] inImm = 16'h0;
    logic [25:0] inTarget = 26'h0;

    logic        rdy8, we8, busy8, done8, err8;
    logic [7:0]  addr8, count8;
    logic [31:0] wdata8;
    logic        rdy4, we4, busy4, done4, err4;
    logic [3:0]  addr4, count4;
    logic [31:0] wdata4;

    int nVec = 0;
    int nMiss = 0;
    int cyc = 0;
    int acc4 = 0;
    logic [31:0] ptr8 = 32'h0, ptr4 = 32'h0;
    logic [63:0] q8[$];
    logic [63:0] q4[$];
    int          wc8[$];
    logic [63:0] e8, e4;
    vec_t        tbl[10];

    instr_encoder_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start8), .in_valid(valid8), .in_ready(rdy8),
        .in_last(inLast), .in_kind(inKind), .in_alufn(inAlufn), .in_rs(inRs),
        .in_rt(inRt), .in_rd(inRd), .in_imm(inImm), .in_target(inTarget),
        .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8), .busy(busy8),
        .done(done8), .err(err8), .count(count8)
    );

    instr_encoder_loader #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(valid4), .in_ready(rdy4),
        .in_last(inLast), .in_kind(inKind), .in_alufn(inAlufn), .in_rs(inRs),
        .in_rt(inRt), .in_rd(inRd), .in_imm(inImm), .in_target(inTarget),
        .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4), .busy(busy4),
        .done(done4), .err(err4), .count(count4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we8 === 1'b1) begin
            wc8.push_back(cyc);
            if (q8.size() == 0) begin
                chk("wr8_unexpected", {24'h0, addr8}, 32'hFFFF_FFFF);
            end else begin
                e8 = q8.pop_front();
                chk("wr8_addr", {24'h0, addr8}, e8[63:32]);
                chk("wr8_data", wdata8, e8[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (we4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("wr4_unexpected", {28'h0, addr4}, 32'hFFFF_FFFF);
            end else begin
                e4 = q4.pop_front();
                chk("wr4_addr", {28'h0, addr4}, e4[63:32]);
                chk("wr4_data", wdata4, e4[31:0]);
            end
        end
    end

    // Drives one bundle; the expected write is queued only if the DUT is ready.
    task automatic send(input int sel, input logic [2:0] kind, input logic [2:0] alufn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                        input logic legal, input logic [31:0] word);
        inKind = kind; inAlufn = alufn; inRs = rs; inRt = rt; inRd = rd;
        inImm = imm; inTarget = tgt; inLast = last;
        if (sel == 0) valid8 = 1'b1; else valid4 = 1'b1;
        @(negedge clk);
        if (sel == 0) begin
            if (rdy8 && legal) begin
                q8.push_back({ptr8, word});
                ptr8 = ptr8 + 4;
            end
        end else if (rdy4) begin
            acc4++;
            if (legal) begin
                q4.push_back({ptr4, word});
                ptr4 = ptr4 + 4;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid8 = 1'b0; valid4 = 1'b0; inLast = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doStart8();
        start8 = 1'b1; ptr8 = 32'h0;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    initial begin
        tbl[0] = '{3'd1, 3'd0, 5'd0,  5'd8,  5'd0,  16'h0005, 26'h0, 32'h20080005};
        tbl[1] = '{3'd4, 3'd0, 5'd29, 5'd9,  5'd0,  16'h0004, 26'h0, 32'h8FA90004};
        tbl[2] = '{3'd2, 3'd0, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0, 32'h1022FFFF};
        tbl[3] = '{3'd0, 3'd1, 5'd4,  5'd5,  5'd6,  16'h0,    26'h0, 32'h00853022};
        tbl[4] = '{3'd0, 3'd2, 5'd7,  5'd8,  5'd9,  16'h0,    26'h0, 32'h00E84824};
        tbl[5] = '{3'd0, 3'd3, 5'd10, 5'd11, 5'd12, 16'h0,    26'h0, 32'h014B6025};
        tbl[6] = '{3'd0, 3'd4, 5'd31, 5'd0,  5'd31, 16'h0,    26'h0, 32'h03E0F82A};
        tbl[7] = '{3'd3, 3'd0, 5'd3,  5'd4,  5'd0,  16'h8000, 26'h0, 32'h14648000};
        tbl[8] = '{3'd1, 3'd0, 5'd2,  5'd3,  5'd31, 16'h1234, 26'h0, 32'h20431234};
        tbl[9] = '{3'd5, 3'd0, 5'd9,  5'd9,  5'd9,  16'hABCD, 26'h0000010, 32'h08000010};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", {31'h0, we8}, 32'h0);
        chk("rst_ready", {31'h0, rdy8}, 32'h0);
        chk("rst_busy_done_err", {29'h0, busy8, done8, err8}, 32'h0);
        chk("rst_count", {24'h0, count8}, 32'h0);
        chk("rst_addr_data", {24'h0, addr8} | wdata8, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        chk("idle_ready", {31'h0, rdy8}, 32'h0);

        // Back-to-back table stream, last on the final entry
        doStart8();
        chk("start_busy", {31'h0, busy8}, 32'h1);
        wc8.delete();
        for (int i = 0; i < 10; i++) begin
            send(0, tbl[i].kind, tbl[i].alufn, tbl[i].rs, tbl[i].rt, tbl[i].rd,
                 tbl[i].imm, tbl[i].tgt, (i == 9), 1'b1, tbl[i].word);
        end
        chk("stream_first_done_we", {30'h0, done8, we8}, 32'h3);
        idle(3);
        chk("stream_done", {31'h0, done8}, 32'h1);
        chk("stream_count", {24'h0, count8}, 32'd10);
        chk("stream_ready", {31'h0, rdy8}, 32'h0);
        chk("stream_err", {31'h0, err8}, 32'h0);
        chk("stream_drained", q8.size(), 32'd0);
        chk("stream_consecutive", (wc8.size() == 10) ? wc8[9] - wc8[0] : -1, 32'd9);

        // Restart from DONE, single RTYPE add with last
        doStart8();
        chk("restart_count", {24'h0, count8}, 32'h0);
        chk("restart_busy", {31'h0, busy8}, 32'h1);
        send(0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00221820);
        chk("single_we_in_done", {30'h0, done8, we8}, 32'h3);
        idle(1);
        chk("single_done", {31'h0, done8}, 32'h1);
        chk("single_count", {24'h0, count8}, 32'h1);

        // Illegal bundles between two legal ones
        doStart8();
        send(0, 3'd1, 3'd0, 5'd1, 5'd1, 5'd0, 16'h0007, 26'h0, 1'b0, 1'b1, 32'h20210007);
        send(0, 3'd6, 3'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0);
        chk("illegal_err_set", {31'h0, err8}, 32'h1);
        send(0, 3'd0, 3'd7, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0);
        send(0, 3'd4, 3'd0, 5'd29, 5'd9, 5'd0, 16'h0004, 26'h0, 1'b1, 1'b1, 32'h8FA90004);
        idle(2);
        chk("illegal_count", {24'h0, count8}, 32'd2);
        chk("illegal_err_sticky", {31'h0, err8}, 32'h1);
        chk("illegal_drained", q8.size(), 32'd0);
        doStart8();
        chk("illegal_err_cleared", {31'h0, err8}, 32'h0);

        // start pulsed in LOAD is ignored
        send(0, 3'd1, 3'd0, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 1'b0, 1'b1, 32'h20080005);
        valid8 = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        send(0, 3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 1'b1, 32'h0BFFFFFF);
        idle(2);
        chk("loadstart_count", {24'h0, count8}, 32'd2);
        chk("loadstart_drained", q8.size(), 32'd0);

        // Async reset during a write cycle
        doStart8();
        send(0, 3'd1, 3'd0, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0, 1'b0, 1'b1, 32'h20080005);
        valid8 = 1'b0;
        chk("prerst_we", {31'h0, we8}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("asyncrst_we", {31'h0, we8}, 32'h0);
        chk("asyncrst_busy", {31'h0, busy8}, 32'h0);
        chk("asyncrst_count", {24'h0, count8}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        q8.delete();
        idle(1);
        chk("postrst_idle", {30'h0, busy8, done8}, 32'h0);
        doStart8();
        send(0, 3'd2, 3'd0, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1, 1'b1, 32'h1022FFFF);
        idle(2);
        chk("postrst_count", {24'h0, count8}, 32'd1);
        chk("postrst_drained", q8.size(), 32'd0);

        // ADDR_WIDTH=4: six bundles, capacity four words
        start4 = 1'b1; ptr4 = 32'h0;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(1, 3'd1, 3'd0, 5'd1, 5'd2, 5'd0, 16'(k + 1), 26'h0, 1'b0, 1'b1,
                 32'h20220000 + 32'(k + 1));
        end
        chk("cap_accepts", acc4, 32'd4);
        idle(3);
        chk("cap_done", {31'h0, done4}, 32'h1);
        chk("cap_count", {28'h0, count4}, 32'd4);
        chk("cap_ready", {31'h0, rdy4}, 32'h0);
        chk("cap_drained", q4.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the main control decoder: builds 32-bit MIPS words from decoded fields for the supported subset (R-type add/sub/and/or/slt, addi, beq, bne, lw, j).
- Streams the words into instruction memory at sequential word addresses, through a valid/ready input handshake and a registered write port.
- Used by the test/boot path to load programs into imem before the core runs.

Parameters:
- ADDR_WIDTH, 8, width of the imem byte address; capacity is 2^ADDR_WIDTH / 4 words.
- BASE_ADDR, 0, first byte address written; must be word-aligned.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new load session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder accepts a bundle this cycle.
- in_last  input  1  the bundle is the final instruction of the program.
- in_kind  input  3  0 RTYPE, 1 ADDI, 2 BEQ, 3 BNE, 4 LW, 5 JUMP; 6-7 illegal.
- in_alufn  input  3  RTYPE only: 0 add (funct 0x20), 1 sub (0x22), 2 and (0x24), 3 or (0x25), 4 slt (0x2A); 5-7 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate / branch offset.
- in_target  input  26  jump target field.
- mem_we  output  1  imem write strobe.
- mem_addr  output  ADDR_WIDTH  imem byte address.
- mem_wdata  output  32  encoded word.
- busy  output  1  state is LOAD.
- done  output  1  state is DONE.
- err  output  1  sticky: an illegal bundle was seen this session.
- count  output  ADDR_WIDTH  words written this session.

Behaviour:
- Reset (async): state IDLE; all outputs 0; write pointer = BASE_ADDR. mem_we drops immediately, including mid-load.
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_ready=0. start=1 -> LOAD; pointer=BASE_ADDR; count=0; err=0.
- DONE: done=1, in_ready=0. start=1 -> LOAD with the same clears as from IDLE.
- LOAD: in_ready=1. start is ignored.
- Accept: occurs on a cycle with in_valid & in_ready. The word is encoded combinationally and registered. On the next cycle mem_we=1 for exactly one cycle, with mem_addr = pointer and mem_wdata = the encoded word. After that write, pointer += 4 and count += 1.
- Latency: one cycle from accept to write; back-to-back accepts give back-to-back writes.
- Encoding:
  - RTYPE: {6'h00, rs, rt, rd, 5'b0, funct}.
  - ADDI: {6'h08, rs, rt, imm}.
  - BEQ: {6'h04, rs, rt, imm}.
  - BNE: {6'h05, rs, rt, imm}.
  - LW: {6'h23, rs, rt, imm}.
  - JUMP: {6'h02, target}.
  - Fields unused by a kind are ignored.
- Illegal kind or illegal alufn on RTYPE: the bundle is consumed, no write occurs, pointer and count are unchanged, err is set and stays set until the next start.
- Termination: an accepted bundle with in_last=1 (legal or illegal), or an accepted legal bundle written to the final word (pointer == 2^ADDR_WIDTH-4), moves the FSM to DONE on the next edge. in_ready is 0 from that edge on, and the last write occurs in the first DONE cycle.
- Wrap-around: never happens; the pointer does not advance past the final word.
- mem_we is never asserted in IDLE, except never at all; in DONE it is asserted only in the first cycle (the final write).

Test Plan:
- start, then RTYPE add rs=1 rt=2 rd=3 with in_last=1 -> one cycle later mem_we=1, mem_addr=0x00, mem_wdata=0x00221820; next cycle done=1, count=1.
- Back-to-back stream (in_valid held high):
  - ADDI rs=0 rt=8 imm=5 -> 0x20080005 @0x00.
  - LW rs=29 rt=9 imm=4 -> 0x8FA90004 @0x04.
  - BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF @0x08.
  - JUMP target=0x10, in_last=1 -> 0x08000010 @0x0C.
  - Required: writes on consecutive cycles; count=4.
- Illegal bundles: in_kind=6, then RTYPE alufn=7 between two legal bundles -> only 2 writes, at 0x00 and 0x04; err=1 after the first illegal bundle; err cleared by the next start.
- ADDR_WIDTH=4: send 6 legal bundles, none with last -> writes at 0x0,0x4,0x8,0xC only; in_ready=0 after the 4th accept; done=1; no 5th write.
- Assert rst for one cycle during a write cycle -> mem_we=0 immediately (async); state IDLE; count=0; a new start restarts at BASE_ADDR.
- start pulsed during LOAD -> ignored, pointer not reset; start pulsed in DONE -> new session at BASE_ADDR with count=0.
